// File: rtl/alu_share_arbiter_if.sv
// Requester-side bundle for the shared ALU arbiter: operation request and result response.
// Handshakes: a transfer happens in any cycle where valid[i] & ready[i] are both high at the rising edge.
interface alu_share_arbiter_if #(
   parameter int N_REQ  = 2,
   parameter int DATA_W = 32
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*DATA_W-1:0] req_a;
   logic [N_REQ*DATA_W-1:0] req_b;
   logic [N_REQ*3-1:0]      req_op;
   logic [N_REQ-1:0]        rsp_valid;
   logic [N_REQ-1:0]        rsp_ready;
   logic [DATA_W-1:0]       rsp_result;
   logic                    rsp_zero;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_zero
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_zero
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one combinational ALU among N_REQ requesters.
// One operation in flight: IDLE (arbitrate/accept) -> EXEC (ALU settles) -> RESP (hold result).
module alu_share_arbiter #(
   parameter int N_REQ  = 2,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_share_arbiter_if.slave bus,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_ctrl,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] op_a_q, op_b_q, rsp_result_q;
   logic [2:0]        op_ctrl_q;
   logic              rsp_zero_q;
   logic [IDX_W-1:0]  grant_q, last_grant_q;
   logic [IDX_W-1:0]  winner;
   logic              found;
   logic [N_REQ-1:0]  req_ready_d, rsp_valid_d;

   // Scan starts just after the last served requester so every holder is reached within N_REQ grants.
   always_comb begin
      int j;
      j      = 0;
      winner = '0;
      found  = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         j = (int'(last_grant_q) + k) % N_REQ;
         if (!found && bus.req_valid[j]) begin
            winner = IDX_W'(j);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      req_ready_d = '0;
      rsp_valid_d = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               req_ready_d[winner] = 1'b1;
               state_d             = EXEC;
            end
         end
         EXEC: state_d = RESP;
         RESP: begin
            rsp_valid_d[grant_q] = 1'b1;
            if (bus.rsp_ready[grant_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_ctrl_q    <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         grant_q      <= '0;
         last_grant_q <= IDX_W'(N_REQ - 1);
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && found) begin
            op_a_q    <= bus.req_a[winner*DATA_W +: DATA_W];
            op_b_q    <= bus.req_b[winner*DATA_W +: DATA_W];
            op_ctrl_q <= bus.req_op[winner*3 +: 3];
            grant_q   <= winner;
         end
         if (state_q == EXEC) begin
            rsp_result_q <= alu_result;
            rsp_zero_q   <= alu_zero;
         end
         if (state_q == RESP && bus.rsp_ready[grant_q]) last_grant_q <= grant_q;
      end
   end

   // The ALU sees the latched operation at all times, so it holds the last op outside EXEC.
   assign alu_a          = op_a_q;
   assign alu_b          = op_b_q;
   assign alu_ctrl       = op_ctrl_q;
   assign bus.req_ready  = req_ready_d;
   assign bus.rsp_valid  = rsp_valid_d;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_zero   = rsp_zero_q;
   assign busy           = (state_q == EXEC) || (state_q == RESP);
   assign dbg_state      = state_q;

endmodule
